// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: 2-flop synchronizer, shared sample prescaler,
// per-bit debounce counters and sticky edge event flags with a combined irq.
module gpio_in_filter #(
  parameter int DW      = 16,
  parameter int PRESC_W = 8,
  parameter int DB_CNT  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      pin_in,
  input  logic [PRESC_W-1:0] presc,
  input  logic [DW-1:0]      rise_en,
  input  logic [DW-1:0]      fall_en,
  input  logic [DW-1:0]      evt_clr,
  output logic [DW-1:0]      gpio_clean,
  output logic [DW-1:0]      evt,
  output logic               irq
);

  localparam int DC_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DB_CNT - 1);

  logic [DW-1:0]            s1_q, s2_q;
  logic [PRESC_W-1:0]       pcnt_q, pcnt_d;
  logic [DW-1:0][DC_W-1:0]  dc_q, dc_d;
  logic [DW-1:0]            clean_q, clean_d;
  logic [DW-1:0]            evt_q, evt_d;
  logic                     tick_s;
  logic [DW-1:0]            rise_s, fall_s;

  // Prescaler reload, debounce counting and event flag next-state.
  always_comb begin
    tick_s  = (pcnt_q == {PRESC_W{1'b0}});
    pcnt_d  = pcnt_q - PRESC_W'(1);
    dc_d    = dc_q;
    clean_d = clean_q;
    if (tick_s) begin
      pcnt_d = presc;
    end else begin
      pcnt_d = pcnt_q - PRESC_W'(1);
    end
    for (int i = 0; i < DW; i++) begin
      if (!tick_s) begin
        dc_d[i] = dc_q[i];
      end else if (s2_q[i] == clean_q[i]) begin
        dc_d[i] = {DC_W{1'b0}};
      end else if (dc_q[i] == DC_LAST) begin
        clean_d[i] = s2_q[i];
        dc_d[i]    = {DC_W{1'b0}};
      end else begin
        dc_d[i] = dc_q[i] + DC_W'(1);
      end
    end
    // Masks are looked at only on the edge where the clean level flips;
    // a set in the same cycle as a clear wins.
    rise_s = clean_d & ~clean_q & rise_en;
    fall_s = ~clean_d & clean_q & fall_en;
    evt_d  = (evt_q & ~evt_clr) | rise_s | fall_s;
  end

  // State registers; everything returns to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= {DW{1'b0}};
      s2_q    <= {DW{1'b0}};
      pcnt_q  <= {PRESC_W{1'b0}};
      dc_q    <= '0;
      clean_q <= {DW{1'b0}};
      evt_q   <= {DW{1'b0}};
    end else begin
      s1_q    <= pin_in;
      s2_q    <= s1_q;
      pcnt_q  <= pcnt_d;
      dc_q    <= dc_d;
      clean_q <= clean_d;
      evt_q   <= evt_d;
    end
  end

  assign gpio_clean = clean_q;
  assign evt        = evt_q;
  assign irq        = |evt_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed self-checking bench for gpio_in_filter (DW=16, PRESC_W=8, DB_CNT=4).
module tb_gpio_in_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pin_in;
  logic [7:0]  presc;
  logic [15:0] rise_en, fall_en, evt_clr;
  logic [15:0] gpio_clean, evt;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  gpio_in_filter #(.DW(16), .PRESC_W(8), .DB_CNT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_in     (pin_in),
    .presc      (presc),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .evt_clr    (evt_clr),
    .gpio_clean (gpio_clean),
    .evt        (evt),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] hist;
    logic        seen;
    int          first_hi;

    rst = 1'b1; pin_in = 16'hFFFF; presc = 8'd0;
    rise_en = 16'hFFFF; fall_en = 16'hFFFF; evt_clr = 16'h0000;

    // Reset values with pins held high.
    cyc(3);
    check_eq("rst_clean", gpio_clean, 16'h0000);
    check_eq("rst_evt", evt, 16'h0000);
    check_eq("rst_irq", irq, 1'b0);

    // Pin high through reset appears after normal latency and raises events.
    #2 rst = 1'b0;
    cyc(5);
    check_eq("post_rst_lat5", gpio_clean, 16'h0000);
    cyc(1);
    check_eq("post_rst_lat6", gpio_clean, 16'hFFFF);
    check_eq("post_rst_evt", evt, 16'hFFFF);
    check_eq("post_rst_irq", irq, 1'b1);

    // Asynchronous reset between edges clears outputs immediately.
    #2 rst = 1'b1;
    #1;
    check_eq("async_clean", gpio_clean, 16'h0000);
    check_eq("async_evt", evt, 16'h0000);
    check_eq("async_irq", irq, 1'b0);
    cyc(2);
    check_eq("hold_rst_clean", gpio_clean, 16'h0000);
    check_eq("hold_rst_evt", evt, 16'h0000);
    pin_in = 16'h0000;
    cyc(1);
    #2 rst = 1'b0;
    cyc(8);
    check_eq("idle_clean", gpio_clean, 16'h0000);
    check_eq("idle_evt", evt, 16'h0000);

    // Latency with presc=0: 6 cycles, not 5.
    pin_in = 16'hFA1C;
    cyc(5);
    check_eq("lat_5", gpio_clean, 16'h0000);
    cyc(1);
    check_eq("lat_6", gpio_clean, 16'hFA1C);
    check_eq("lat_evt", evt, 16'hFA1C);
    check_eq("lat_irq", irq, 1'b1);

    evt_clr = 16'hFFFF; cyc(1); evt_clr = 16'h0000;
    check_eq("clr_all_evt", evt, 16'h0000);
    check_eq("clr_all_irq", irq, 1'b0);

    // 3-cycle glitch on bit 0 is rejected.
    pin_in = 16'hFA1D;
    cyc(3);
    pin_in = 16'hFA1C;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      seen = seen | gpio_clean[0] | evt[0];
    end
    check_eq("glitch3_seen", seen, 1'b0);

    // 4-cycle pulse passes: high for cycles 6..9 after the input rise.
    pin_in = 16'hFA1D;
    hist = 16'h0000;
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      if (k == 4) pin_in = 16'hFA1C;
      hist[k-1] = gpio_clean[0];
    end
    check_eq("pulse4_shape", hist, 16'h01E0);
    check_eq("pulse4_evt", evt, 16'h0001);
    evt_clr = 16'hFFFF; cyc(1); evt_clr = 16'h0000;

    // Prescaler=3: bit 5 rises within 15..18 cycles, never earlier.
    presc = 8'd3;
    cyc(8);
    pin_in = 16'hFA3C;
    first_hi = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      if (first_hi == 0 && gpio_clean[5]) first_hi = k;
    end
    check_eq("presc_window", (first_hi >= 15 && first_hi <= 18), 1'b1);
    check_eq("presc_clean", gpio_clean, 16'hFA3C);
    presc = 8'd0;
    cyc(8);

    // Event masking: rise masked, fall enabled on bit 0.
    evt_clr = 16'hFFFF; cyc(1); evt_clr = 16'h0000;
    rise_en = 16'h0000; fall_en = 16'h0001;
    pin_in = 16'hFA3D;
    cyc(8);
    check_eq("mask_rise_clean", gpio_clean, 16'hFA3D);
    check_eq("mask_rise_evt", evt, 16'h0000);
    pin_in = 16'hFA3C;
    cyc(6);
    check_eq("mask_fall_clean", gpio_clean, 16'hFA3C);
    check_eq("mask_fall_evt", evt, 16'h0001);
    check_eq("mask_fall_irq", irq, 1'b1);

    // Clear on the same edge as a new fall event: set wins.
    pin_in = 16'hFA3D;
    cyc(8);
    pin_in = 16'hFA3C;
    cyc(5);
    check_eq("setclr_pre_clean", gpio_clean, 16'hFA3D);
    evt_clr = 16'h0001;
    cyc(1);
    evt_clr = 16'h0000;
    check_eq("setclr_clean", gpio_clean, 16'hFA3C);
    check_eq("setclr_evt", evt, 16'h0001);

    // Lone clear.
    cyc(2);
    evt_clr = 16'h0001;
    cyc(1);
    evt_clr = 16'h0000;
    check_eq("lone_clr_evt", evt, 16'h0000);
    check_eq("lone_clr_irq", irq, 1'b0);

    // Reset mid-debounce restarts the count.
    rise_en = 16'hFFFF; fall_en = 16'hFFFF;
    pin_in = 16'h0000;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(8);
    check_eq("mid_pre_clean", gpio_clean, 16'h0000);
    pin_in = 16'h0004;
    cyc(4);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_clean", gpio_clean, 16'h0000);
    cyc(1);
    rst = 1'b0;
    cyc(5);
    check_eq("mid_lat5", gpio_clean, 16'h0000);
    cyc(1);
    check_eq("mid_lat6", gpio_clean, 16'h0004);
    check_eq("mid_evt", evt, 16'h0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_in_filter.md
# gpio_in_filter

Input conditioning stage that sits directly upstream of the SoC `gpio_in` port. Raw, asynchronous pin levels are brought into the `clk` domain through a 2-flop synchronizer. Each bit is then debounced over a programmable sample tick, and the filtered word `gpio_clean` drives the SoC `gpio_in` bus. Per-bit rise/fall event flags and a combined `irq` are also produced, so firmware can poll or clear edges instead of sampling levels.

## Interface
Parameters:
- `DW`, 16, data width; matches SoC GPIO width.
- `PRESC_W`, 8, width of the sample prescaler.
- `DB_CNT`, 4, number of consecutive differing samples required to accept a new level; legal range 1..16.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `pin_in`  in  DW  raw pin levels; asynchronous to `clk`.
- `presc`  in  PRESC_W  sample tick period minus 1; 0 = sample every cycle.
- `rise_en`  in  DW  per-bit enable for rising-edge events.
- `fall_en`  in  DW  per-bit enable for falling-edge events.
- `evt_clr`  in  DW  single-cycle, write-1-to-clear strobe for `evt`.
- `gpio_clean`  out  DW  debounced levels; connects to SoC `gpio_in`.
- `evt`  out  DW  sticky per-bit edge flags.
- `irq`  out  1  OR-reduction of `evt`.

## Operation
- **Synchronizer:** `s1 <= pin_in`, `s2 <= s1`. Both registers reset to 0. Only `s2` is used downstream.
- **Prescaler:**
  - Down-counter `pcnt` (PRESC_W bits), reset value 0.
  - `tick = (pcnt == 0)`.
  - On tick, `pcnt <= presc`; otherwise `pcnt <= pcnt - 1`.
  - A change to `presc` takes effect at the next reload.
- **Per-bit debouncer, bit i:** counter `dc[i]` of width `$clog2(DB_CNT)` (minimum 1 bit), reset value 0. On tick:
  - If `s2[i] == gpio_clean[i]`: `dc[i] <= 0` (glitch discarded).
  - Else if `dc[i] == DB_CNT-1`: `gpio_clean[i] <= s2[i]` and `dc[i] <= 0`.
  - Else: `dc[i] <= dc[i] + 1`.
  - With no tick, `dc[i]` and `gpio_clean[i]` hold.
  - `DB_CNT = 1`: a level is accepted on the first differing tick.
- **Events:**
  - `evt[i]` sets on the same edge that `gpio_clean[i]` flips 0->1 if `rise_en[i]`, or flips 1->0 if `fall_en[i]`.
  - `evt[i]` clears when `evt_clr[i]` is high.
  - Set and clear in the same cycle: set wins and the flag stays 1.
  - Masks are sampled at the flip edge only. Changing a mask never creates or removes an event retroactively.
- **Interrupt:** `irq = |evt`, combinational from the `evt` flops. There is no other logic in the path.
- **Reset** (asynchronous, any time, including mid-debounce):
  - `s1`, `s2`, `pcnt`, `dc`, `gpio_clean`, `evt` all go to 0; `irq` is 0.
  - After release, the first tick occurs in the first clock cycle.
  - A pin held high through reset appears on `gpio_clean` after the normal latency. Because `gpio_clean` resets to 0, that transition raises a rise event if `rise_en` is set.

## Timing
- Edge 0 is the first `clk` edge with the new `pin_in` level stable before it.
- Synchronizer: `s2` shows the new level after edge 1.
- With `presc = 0`:
  - `gpio_clean` changes at edge `1 + DB_CNT`; with `DB_CNT = 4` that is edge 5.
  - Total latency is `2 + DB_CNT` cycles.
- With `presc = P`, latency depends on tick phase:
  - Minimum `2 + (DB_CNT-1)*(P+1) + 1` cycles.
  - Maximum `2 + DB_CNT*(P+1)` cycles.
- `evt` and `irq` rise on the same edge as `gpio_clean`. `evt_clr` takes effect on the next edge.
- Rejection: a pulse whose `s2` image spans fewer than DB_CNT ticks never reaches `gpio_clean`. With `presc = 0`, that means fewer than DB_CNT cycles.
- All outputs are registered except `irq`, which is one OR level after the `evt` flops.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges. Required: `gpio_clean`, `evt` and `irq` are 0 immediately. Hold `pin_in = 16'hFFFF` during reset; none change until `rst` falls.
- **Latency:** `presc = 0`, `DB_CNT = 4`, all `rise_en`/`fall_en` = 1, `pin_in` goes 0 -> `16'hFA1C`. Required: `gpio_clean = 16'hFA1C` exactly 6 cycles later (not 5), `evt = 16'hFA1C`, `irq = 1`.
- **Glitch rejection:** pulse bit 0 high for 3 cycles, then low. Required: `gpio_clean[0]` stays 0, `evt[0]` stays 0. Repeat with a 4-cycle pulse: `gpio_clean[0]` goes 1 for exactly 4 cycles, starting 6 cycles after the rising input edge.
- **Prescaler:** `presc = 3`, step bit 5 high. Required: `gpio_clean[5]` rises between 15 and 18 cycles after the step; it never rises earlier.
- **Event masking and clear:**
  - `rise_en = 0`, `fall_en = 16'h0001`: a bit-0 rise yields no event; the following fall sets `evt[0]`.
  - Pulse `evt_clr[0]` on the same cycle as a new fall event: `evt[0]` stays 1.
  - A later lone `evt_clr[0]`: `evt[0]` is 0 and `irq` is 0 on the next edge.
- **Reset mid-debounce:** assert `rst` 3 cycles into a 0->1 debounce of bit 2, then release with the pin still high. Required: the count restarts, and `gpio_clean[2]` rises 6 cycles after release (`presc = 0`).
